aes_decrypt_iter: RTL

//  Iterative AES-128 decryption core: the inverse partner of the AES-128 encryption datapath.

---
 rtl/aes_decrypt_iter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryption core: expands the key forward to round key 10, then
// runs ten inverse rounds one per cycle while rewinding the key schedule in step.
module aes_decrypt_iter #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid never depends on ready, and data is only meaningful while valid is high.
    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    state_t       state, state_nxt;
    logic [127:0] st, rk, cache_key, cache_k10;
    logic [7:0]   rcon;
    logic [3:0]   cnt;
    logic         cache_vld;

    logic         accept, cache_hit;
    logic [31:0]  sched_w, sub_w;
    logic [127:0] k_fwd, k_inv, round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] a);
        return a[0] ? (((a ^ 8'h1b) >> 1) | 8'h80) : (a >> 1);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] a);
        return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    // Byte 0 is the most significant byte; state s(r,c) is byte 4c+r.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [0:15][7:0] si, so, kb;
        logic [0:3][31:0] cols;
        si = s;
        kb = k;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                so[4'(4 * c + r)] = aes_inv_sbox(si[4'(4 * ((c - r) & 3) + r)]) ^ kb[4'(4 * c + r)];
            end
        end
        cols = so;
        if (!last) begin
            for (int c = 0; c < 4; c++) cols[2'(c)] = inv_mix_col(cols[2'(c)]);
        end
        return cols;
    endfunction

    assign accept    = in_valid && in_ready;
    assign cache_hit = KEY_CACHE && cache_vld && (key == cache_key);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == KEXP) || (state == ROUND);

    // One shared SubWord(RotWord) serves both schedule directions.
    always_comb begin
        sched_w   = (state == ROUND) ? (rk[31:0] ^ rk[63:32]) : rk[31:0];
        sub_w     = {aes_sbox(sched_w[23:16]), aes_sbox(sched_w[15:8]),
                     aes_sbox(sched_w[7:0]), aes_sbox(sched_w[31:24])};
        k_fwd[127:96] = rk[127:96] ^ sub_w ^ {rcon, 24'h0};
        k_fwd[95:64]  = rk[95:64] ^ k_fwd[127:96];
        k_fwd[63:32]  = rk[63:32] ^ k_fwd[95:64];
        k_fwd[31:0]   = rk[31:0] ^ k_fwd[63:32];
        k_inv[31:0]   = rk[31:0] ^ rk[63:32];
        k_inv[63:32]  = rk[63:32] ^ rk[95:64];
        k_inv[95:64]  = rk[95:64] ^ rk[127:96];
        k_inv[127:96] = rk[127:96] ^ sub_w ^ {rcon, 24'h0};
        round_out     = inv_round(st, k_inv, cnt == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = cache_hit ? ROUND : KEXP;
            KEXP:    if (cnt == 4'd9) state_nxt = ROUND;
            ROUND:   if (cnt == 4'd0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= '0;
            rk        <= '0;
            rcon      <= '0;
            cnt       <= '0;
            data_out  <= '0;
            cache_key <= '0;
            cache_k10 <= '0;
            cache_vld <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (cache_hit) begin
                        rk   <= cache_k10;
                        st   <= data_in ^ cache_k10;
                        rcon <= 8'h36;
                        cnt  <= 4'd9;
                    end else begin
                        rk        <= key;
                        st        <= data_in;
                        rcon      <= 8'h01;
                        cnt       <= 4'd0;
                        cache_key <= key;
                        cache_vld <= 1'b0;
                    end
                end
                KEXP: begin
                    rk <= k_fwd;
                    // rcon stays at 0x36 on the last step: it is the first value the rewind needs.
                    if (cnt == 4'd9) begin
                        st        <= st ^ k_fwd;
                        cache_k10 <= k_fwd;
                        cache_vld <= 1'b1;
                    end else begin
                        rcon <= xtime(rcon);
                        cnt  <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    st   <= round_out;
                    rk   <= k_inv;
                    rcon <= inv_xtime(rcon);
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd0) data_out <= round_out;
                end
                default: ;
            endcase
        end
    end
endmodule
